// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for the MIPS datapath.
//   It decodes op/funct from the IR and drives the ALU operation code and
//   the operand selects. It resolves branches from the ALU compare flags.
//   It sequences the PC, IR, register-file and data-memory write enables.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   op, funct           IR[31:26], IR[5:0]
//   zero, big, smal     ALU flags (A==B, A>B, A<B signed); used only in BR
//   ALUop               ALU operation code
//   alu_srca, alu_srcb  ALU operand selects
//   ext_op              immediate extension mode
//   i_or_d              memory address select
//   pc_wr, ir_wr,
//   rf_wr, dm_wr        write enables
//   pc_src, reg_dst,
//   wd_sel              next-PC / destination / write-data selects
//   illegal             one-cycle pulse on an undecodable instruction
//
// state | meaning
// IDLE  | post-reset idle, no writes
// FETCH | read instruction into IR, PC <= PC+4
// DCD   | decode, ALUOut <= branch target
// MA    | memory address calculation (lw/sw)
// MR    | memory read (lw)
// MWB   | MDR to register file (lw)
// MW    | memory write (sw)
// EXE   | ALU operation (R-type / I-type ALU)
// AWB   | ALUOut to register file
// BR    | branch compare, conditional PC load
// JMP   | jump, jal also links $31
module mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       big,
  input  logic       smal,
  output logic [3:0] ALUop,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic [1:0] ext_op,
  output logic       i_or_d,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       rf_wr,
  output logic       dm_wr,
  output logic [1:0] pc_src,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DCD, S_MA, S_MR, S_MWB, S_MW, S_EXE, S_AWB, S_BR, S_JMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;
  localparam logic [3:0] ALU_SLT = 4'b1100;

  state_t state, next_state;

  logic       r_ok;
  logic [3:0] r_aluop;
  logic       is_rtype;
  logic       br_taken;
  // smal carries no information beyond zero/big for the supported branches
  logic       unused_flags;

  assign unused_flags = smal;
  assign is_rtype     = (op == OP_RTYPE);

  always_comb begin
    r_ok    = 1'b1;
    r_aluop = ALU_ADD;
    case (funct)
      6'b100001: r_aluop = ALU_ADD;
      6'b100011: r_aluop = ALU_SUB;
      6'b100100: r_aluop = ALU_AND;
      6'b100101: r_aluop = ALU_OR;
      6'b100110: r_aluop = ALU_XOR;
      6'b101010: r_aluop = ALU_SLT;
      default:   r_ok    = 1'b0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (op)
      OP_BEQ:  br_taken = zero;
      OP_BNE:  br_taken = !zero;
      OP_BGTZ: br_taken = big;
      OP_BLEZ: br_taken = !big;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    ALUop      = ALU_ADD;
    alu_srca   = 1'b0;
    alu_srcb   = 2'b00;
    ext_op     = 2'b00;
    i_or_d     = 1'b0;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    rf_wr      = 1'b0;
    dm_wr      = 1'b0;
    pc_src     = 2'b00;
    reg_dst    = 2'b00;
    wd_sel     = 2'b00;
    illegal    = 1'b0;

    case (state)
      S_IDLE: next_state = S_FETCH;

      S_FETCH: begin
        ir_wr      = 1'b1;
        alu_srcb   = 2'b01;
        pc_wr      = 1'b1;
        next_state = S_DCD;
      end

      S_DCD: begin
        alu_srcb = 2'b11;
        ext_op   = 2'b01;
        case (op)
          OP_LW, OP_SW:                  next_state = S_MA;
          OP_ADDIU, OP_ORI, OP_LUI:      next_state = S_EXE;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: next_state = S_BR;
          OP_J, OP_JAL:                  next_state = S_JMP;
          OP_RTYPE: begin
            if (r_ok) next_state = S_EXE;
            else      illegal    = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end

      S_MA: begin
        alu_srca   = 1'b1;
        alu_srcb   = 2'b10;
        ext_op     = 2'b01;
        next_state = (op == OP_SW) ? S_MW : S_MR;
      end

      S_MR: begin
        i_or_d     = 1'b1;
        next_state = S_MWB;
      end

      S_MWB: begin
        rf_wr  = 1'b1;
        wd_sel = 2'b01;
      end

      S_MW: begin
        i_or_d = 1'b1;
        dm_wr  = 1'b1;
      end

      S_EXE: begin
        alu_srca   = 1'b1;
        next_state = S_AWB;
        if (is_rtype) begin
          alu_srcb = 2'b00;
          ALUop    = r_aluop;
        end else begin
          alu_srcb = 2'b10;
          case (op)
            OP_ORI: begin
              ext_op = 2'b00;
              ALUop  = ALU_OR;
            end
            // rs is $0, so or-ing passes imm<<16 straight through
            OP_LUI: begin
              ext_op = 2'b10;
              ALUop  = ALU_OR;
            end
            default: begin
              ext_op = 2'b01;
              ALUop  = ALU_ADD;
            end
          endcase
        end
      end

      S_AWB: begin
        rf_wr   = 1'b1;
        reg_dst = is_rtype ? 2'b01 : 2'b00;
      end

      S_BR: begin
        alu_srca = 1'b1;
        ALUop    = ALU_SUB;
        pc_src   = 2'b01;
        pc_wr    = br_taken;
      end

      S_JMP: begin
        pc_wr  = 1'b1;
        pc_src = 2'b10;
        // PC was already advanced in FETCH, so it holds the link address
        if (op == OP_JAL) begin
          rf_wr   = 1'b1;
          reg_dst = 2'b10;
          wd_sel  = 2'b10;
        end
      end

      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: cycle-by-cycle vector table plus short hand sequences
// for instruction length and write-pulse counts.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0, big = 1'b0, smal = 1'b0;
  logic [3:0] ALUop;
  logic       alu_srca, i_or_d, pc_wr, ir_wr, rf_wr, dm_wr, illegal;
  logic [1:0] alu_srcb, ext_op, pc_src, reg_dst, wd_sel;

  int checks = 0;
  int errors = 0;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
    .zero(zero), .big(big), .smal(smal),
    .ALUop(ALUop), .alu_srca(alu_srca), .alu_srcb(alu_srcb), .ext_op(ext_op),
    .i_or_d(i_or_d), .pc_wr(pc_wr), .ir_wr(ir_wr), .rf_wr(rf_wr), .dm_wr(dm_wr),
    .pc_src(pc_src), .reg_dst(reg_dst), .wd_sel(wd_sel), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero, big, smal;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];

  // {ALUop, srca, srcb, ext, i_or_d, pc_wr, ir_wr, rf_wr, dm_wr, pc_src, reg_dst, wd_sel, illegal}
  function automatic logic [20:0] mk(input logic [3:0] alu, input logic sa,
      input logic [1:0] sb, input logic [1:0] ex, input logic iod,
      input logic pw, input logic iw, input logic rw, input logic dw,
      input logic [1:0] ps, input logic [1:0] rd, input logic [1:0] wd,
      input logic il);
    return {alu, sa, sb, ex, iod, pw, iw, rw, dw, ps, rd, wd, il};
  endfunction

  logic [20:0] e_idle, e_fetch, e_dcd, e_dcd_ill, e_ma, e_mr, e_mwb, e_mw;
  logic [20:0] e_exe_slt, e_awb_r, e_awb_i, e_br_t, e_br_n, e_jal, e_j;
  logic [20:0] e_exe_addiu, e_exe_ori, e_exe_lui;

  task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic b, input logic s, input logic [20:0] e);
    vec_t v;
    v.rst_n = r; v.op = o; v.funct = f; v.zero = z; v.big = b; v.smal = s; v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic logic [20:0] outs();
    return {ALUop, alu_srca, alu_srcb, ext_op, i_or_d, pc_wr, ir_wr, rf_wr, dm_wr,
            pc_src, reg_dst, wd_sel, illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // wait at negedge sample points until ir_wr (FETCH); returns 0 on timeout
  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (ir_wr === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // from a FETCH sample, run one instruction; report cycle length and pulses
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input int exp_cycles, input logic [3:0] exe_alu,
                           input int exe_idx, input int exp_dm, input int exp_rf);
    bit ok;
    int cyc, dm_cnt, rf_cnt;
    op = o; funct = f;
    wait_fetch(ok);
    check({name, "_sync"}, {31'd0, ok}, 32'd1);
    cyc = 1; dm_cnt = 0; rf_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (ir_wr === 1'b1) break;
      cyc++;
      if (cyc == exe_idx) check({name, "_aluop"}, {28'd0, ALUop}, {28'd0, exe_alu});
      if (dm_wr === 1'b1) dm_cnt++;
      if (rf_wr === 1'b1) rf_cnt++;
    end
    check({name, "_cycles"}, cyc, exp_cycles);
    check({name, "_dm_pulses"}, dm_cnt, exp_dm);
    check({name, "_rf_pulses"}, rf_cnt, exp_rf);
  endtask

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, BLEZ = 6'b000110, BGTZ = 6'b000111;
  localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, ADDIU = 6'b001001;
  localparam logic [5:0] ORI = 6'b001101, LUI = 6'b001111, BAD = 6'b111111;
  localparam logic [5:0] F_SLT = 6'b101010, F_ADDU = 6'b100001;

  initial begin
    e_idle      = mk(4'b0010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    e_fetch     = mk(4'b0010, 0, 2'b01, 2'b00, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    e_dcd       = mk(4'b0010, 0, 2'b11, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    e_dcd_ill   = mk(4'b0010, 0, 2'b11, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
    e_ma        = mk(4'b0010, 1, 2'b10, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    e_mr        = mk(4'b0010, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    e_mwb       = mk(4'b0010, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 0);
    e_mw        = mk(4'b0010, 0, 2'b00, 2'b00, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0);
    e_exe_slt   = mk(4'b1100, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    e_exe_addiu = mk(4'b0010, 1, 2'b10, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    e_exe_ori   = mk(4'b0001, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    e_exe_lui   = mk(4'b0001, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    e_awb_r     = mk(4'b0010, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b00, 0);
    e_awb_i     = mk(4'b0010, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
    e_br_t      = mk(4'b0000, 1, 2'b00, 2'b00, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    e_br_n      = mk(4'b0000, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    e_jal       = mk(4'b0010, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 2'b10, 2'b10, 2'b10, 0);
    e_j         = mk(4'b0010, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0);

    // reset held, then released: one IDLE cycle before FETCH
    add(0, R, F_SLT, 0, 0, 0, e_idle);
    add(0, R, F_SLT, 0, 0, 0, e_idle);
    add(0, R, F_SLT, 0, 0, 0, e_idle);
    add(1, R, F_SLT, 0, 0, 0, e_idle);
    // slt
    add(1, R, F_SLT, 0, 0, 0, e_fetch);
    add(1, R, F_SLT, 0, 0, 0, e_dcd);
    add(1, R, F_SLT, 1, 1, 0, e_exe_slt);
    add(1, R, F_SLT, 0, 0, 0, e_awb_r);
    // lw
    add(1, LW, 6'd0, 0, 0, 0, e_fetch);
    add(1, LW, 6'd0, 0, 0, 0, e_dcd);
    add(1, LW, 6'd0, 0, 0, 0, e_ma);
    add(1, LW, 6'd0, 0, 0, 0, e_mr);
    add(1, LW, 6'd0, 0, 0, 0, e_mwb);
    // sw
    add(1, SW, 6'd0, 0, 0, 0, e_fetch);
    add(1, SW, 6'd0, 0, 0, 0, e_dcd);
    add(1, SW, 6'd0, 0, 0, 0, e_ma);
    add(1, SW, 6'd0, 0, 0, 0, e_mw);
    // beq taken / not taken (flags outside BR deliberately contradict)
    add(1, BEQ, 6'd0, 0, 0, 0, e_fetch);
    add(1, BEQ, 6'd0, 0, 0, 0, e_dcd);
    add(1, BEQ, 6'd0, 1, 0, 0, e_br_t);
    add(1, BEQ, 6'd0, 1, 0, 0, e_fetch);
    add(1, BEQ, 6'd0, 1, 0, 0, e_dcd);
    add(1, BEQ, 6'd0, 0, 1, 0, e_br_n);
    // bgtz big=0 smal=1 not taken
    add(1, BGTZ, 6'd0, 0, 1, 0, e_fetch);
    add(1, BGTZ, 6'd0, 0, 1, 0, e_dcd);
    add(1, BGTZ, 6'd0, 0, 0, 1, e_br_n);
    // blez big=0 taken
    add(1, BLEZ, 6'd0, 0, 1, 0, e_fetch);
    add(1, BLEZ, 6'd0, 0, 1, 0, e_dcd);
    add(1, BLEZ, 6'd0, 0, 0, 1, e_br_t);
    // bne zero=0 taken
    add(1, BNE, 6'd0, 1, 0, 0, e_fetch);
    add(1, BNE, 6'd0, 1, 0, 0, e_dcd);
    add(1, BNE, 6'd0, 0, 1, 0, e_br_t);
    // jal
    add(1, JAL, 6'd0, 0, 0, 0, e_fetch);
    add(1, JAL, 6'd0, 0, 0, 0, e_dcd);
    add(1, JAL, 6'd0, 0, 0, 0, e_jal);
    // illegal op, then illegal funct
    add(1, BAD, 6'd0, 0, 0, 0, e_fetch);
    add(1, BAD, 6'd0, 0, 0, 0, e_dcd_ill);
    add(1, R, 6'b000111, 0, 0, 0, e_fetch);
    add(1, R, 6'b000111, 0, 0, 0, e_dcd_ill);
    // addiu, ori, lui
    add(1, ADDIU, 6'd0, 0, 0, 0, e_fetch);
    add(1, ADDIU, 6'd0, 0, 0, 0, e_dcd);
    add(1, ADDIU, 6'd0, 0, 0, 0, e_exe_addiu);
    add(1, ADDIU, 6'd0, 0, 0, 0, e_awb_i);
    add(1, ORI, 6'd0, 0, 0, 0, e_fetch);
    add(1, ORI, 6'd0, 0, 0, 0, e_dcd);
    add(1, ORI, 6'd0, 0, 0, 0, e_exe_ori);
    add(1, ORI, 6'd0, 0, 0, 0, e_awb_i);
    add(1, LUI, 6'd0, 0, 0, 0, e_fetch);
    add(1, LUI, 6'd0, 0, 0, 0, e_dcd);
    add(1, LUI, 6'd0, 0, 0, 0, e_exe_lui);
    add(1, LUI, 6'd0, 0, 0, 0, e_awb_i);
    // j
    add(1, J, 6'd0, 0, 0, 0, e_fetch);
    add(1, J, 6'd0, 0, 0, 0, e_dcd);
    add(1, J, 6'd0, 0, 0, 0, e_j);
    // lw aborted by reset during MR
    add(1, LW, 6'd0, 0, 0, 0, e_fetch);
    add(1, LW, 6'd0, 0, 0, 0, e_dcd);
    add(1, LW, 6'd0, 0, 0, 0, e_ma);
    add(0, LW, 6'd0, 0, 0, 0, e_idle);
    add(0, LW, 6'd0, 0, 0, 0, e_idle);
    add(1, LW, 6'd0, 0, 0, 0, e_idle);
    add(1, R, F_ADDU, 0, 0, 0, e_fetch);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      op    = vecs[i].op;
      funct = vecs[i].funct;
      zero  = vecs[i].zero;
      big   = vecs[i].big;
      smal  = vecs[i].smal;
      #1;
      checks++;
      if (outs() !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d op=%b funct=%b: got %b expected %b",
                 i, vecs[i].op, vecs[i].funct, outs(), vecs[i].exp);
      end
    end

    // instruction lengths, EXE ALUop per funct, write-pulse counts
    // (EXE is cycle 3 counting FETCH as 1)
    run_instr("subu", R, 6'b100011, 4, 4'b0000, 3, 0, 1);
    run_instr("and",  R, 6'b100100, 4, 4'b1001, 3, 0, 1);
    run_instr("or",   R, 6'b100101, 4, 4'b0001, 3, 0, 1);
    run_instr("xor",  R, 6'b100110, 4, 4'b1010, 3, 0, 1);
    run_instr("addu", R, F_ADDU,    4, 4'b0010, 3, 0, 1);
    run_instr("lw",   LW, 6'd0,     5, 4'b0010, 3, 0, 1);
    run_instr("sw",   SW, 6'd0,     4, 4'b0010, 3, 1, 0);
    run_instr("jal",  JAL, 6'd0,    3, 4'b0010, 3, 0, 1);
    run_instr("ill",  BAD, 6'd0,    2, 4'b0010, 2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
